// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared elevator encodings, car state enum and defaults
//
// Purpose: single source of the engine command encodings, the car state
// enum and the default floor count, shared by the car plant and the
// movement controller.
// Ports: none (package).
package elevator_pkg;

  localparam int DEFAULT_NUM_FLOORS = 3;

  localparam logic [1:0] ENG_STOP = 2'b00;
  localparam logic [1:0] ENG_UP   = 2'b01;
  localparam logic [1:0] ENG_DOWN = 2'b10;
  localparam logic [1:0] ENG_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVING,
    ST_OPENING,
    ST_OPEN,
    ST_CLOSING
  } car_state_t;

endpackage

// File: rtl/car_plant_if.sv
// rtl/car_plant_if.sv - controller <-> car plant command/status interface
//
// Purpose: bundles the movement controller's commands and the car plant's
// status reports.
// Signals:
//   engine    : motor command (stop/up/down/reserved), controller -> plant
//   doors     : per-floor door open request, controller -> plant
//   floor     : one-hot current/last-passed floor, plant -> controller
//   moving    : car between floors, plant -> controller
//   arrive    : one-cycle pulse per floor reached, plant -> controller
//   door_open : per-floor door fully open, plant -> controller
//   fault     : sticky illegal-command flag, plant -> controller
// Modports: master = controller side, slave = car plant side.
interface car_plant_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS
) ();

  logic [1:0]            engine;
  logic [NUM_FLOORS-1:0] doors;
  logic [NUM_FLOORS-1:0] floor;
  logic                  moving;
  logic                  arrive;
  logic [NUM_FLOORS-1:0] door_open;
  logic                  fault;

  modport master (
    output engine, doors,
    input  floor, moving, arrive, door_open, fault
  );

  modport slave (
    input  engine, doors,
    output floor, moving, arrive, door_open, fault
  );

endinterface

// File: rtl/car_plant_shaft_timer.sv
// rtl/car_plant_shaft_timer.sv - loadable down-counter for travel and door timing
//
// Purpose: counts down from a loaded value and reports when it sits at 0.
// Ports:
//   CLK        : clock, rising edge
//   RST        : asynchronous active-low reset (count clears to 0)
//   load       : load load_value this cycle (takes priority over counting)
//   load_value : value to load
//   done       : count is 0
module shaft_timer #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/car_plant.sv
// rtl/car_plant.sv - elevator car and shaft model responding to the movement controller
//
// Purpose: consumes engine/door commands, times floor-to-floor travel and
// door motion, reports position/arrival/door status and flags illegal
// commands (which are otherwise ignored).
// Ports:
//   CLK : clock, rising edge
//   RST : asynchronous active-low reset (car returns to floor 0, doors closed)
//   bus : car_plant_if slave modport (commands in, status out)
module car_plant
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = DEFAULT_NUM_FLOORS,
  parameter int TRAVEL_TICKS = 8,
  parameter int DOOR_TICKS   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  car_plant_if.slave bus
);

  localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int TW        = $clog2(MAX_TICKS);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_TICKS - 1);

  car_state_t            r_state;
  car_state_t            w_state_nxt;
  logic                  r_dir_up;
  logic                  w_dir_up_nxt;
  logic [NUM_FLOORS-1:0] r_floor;
  logic [NUM_FLOORS-1:0] w_floor_nxt;
  logic [NUM_FLOORS-1:0] w_floor_shift;
  logic [NUM_FLOORS-1:0] r_door_open;
  logic [NUM_FLOORS-1:0] w_door_open_nxt;
  logic                  r_moving;
  logic                  r_arrive;
  logic                  r_fault;
  logic                  w_fault_nxt;
  logic                  w_load;
  logic [TW-1:0]         w_load_value;
  logic                  w_done;
  logic                  w_door_req;
  logic                  w_door_hold;
  logic                  w_at_top;
  logic                  w_at_bottom;
  logic                  w_shift_end;
  logic                  w_continue;

  // A door request is honoured only when the current floor's bit is the
  // sole bit set; any other bit makes the whole request illegal.
  assign w_door_req  = (bus.doors == r_floor);
  assign w_door_hold = |(bus.doors & r_floor);
  assign w_at_top    = r_floor[NUM_FLOORS-1];
  assign w_at_bottom = r_floor[0];

  // One-hot shift in the travel direction, held at the end stops.
  assign w_floor_shift = r_dir_up ? (w_at_top    ? r_floor : (r_floor << 1))
                                  : (w_at_bottom ? r_floor : (r_floor >> 1));
  assign w_shift_end   = r_dir_up ? w_floor_shift[NUM_FLOORS-1] : w_floor_shift[0];
  assign w_continue    = (bus.engine == (r_dir_up ? ENG_UP : ENG_DOWN)) && !w_shift_end;

  // Travel and door motion never overlap, so one timer serves both.
  shaft_timer #(.WIDTH(TW)) u_shaft_timer (
    .CLK        (CLK),
    .RST        (RST),
    .load       (w_load),
    .load_value (w_load_value),
    .done       (w_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dir_up_nxt = r_dir_up;
    w_load       = 1'b0;
    w_load_value = TRAVEL_LOAD;
    case (r_state)
      ST_IDLE: begin
        if (w_door_req) begin
          w_state_nxt  = ST_OPENING;
          w_load       = 1'b1;
          w_load_value = DOOR_LOAD;
        end else if (bus.engine == ENG_UP && !w_at_top) begin
          w_state_nxt  = ST_MOVING;
          w_dir_up_nxt = 1'b1;
          w_load       = 1'b1;
        end else if (bus.engine == ENG_DOWN && !w_at_bottom) begin
          w_state_nxt  = ST_MOVING;
          w_dir_up_nxt = 1'b0;
          w_load       = 1'b1;
        end
      end
      ST_MOVING: begin
        if (w_done) begin
          if (w_continue) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_OPENING: begin
        if (w_done) begin
          w_state_nxt = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (!w_door_hold) begin
          w_state_nxt  = ST_CLOSING;
          w_load       = 1'b1;
          w_load_value = DOOR_LOAD;
        end
      end
      ST_CLOSING: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_floor_nxt     = r_floor;
    w_door_open_nxt = (w_state_nxt == ST_OPEN) ? r_floor : '0;
    w_fault_nxt     = r_fault;

    if (r_state == ST_MOVING && w_done) begin
      w_floor_nxt = w_floor_shift;
    end

    if (bus.engine == ENG_RSVD) begin
      w_fault_nxt = 1'b1;
    end
    // Covers both a wrong-floor request and more than one bit set.
    if ((bus.doors & ~r_floor) != '0) begin
      w_fault_nxt = 1'b1;
    end
    case (r_state)
      ST_IDLE: begin
        if ((bus.engine == ENG_UP && w_at_top) || (bus.engine == ENG_DOWN && w_at_bottom)) begin
          w_fault_nxt = 1'b1;
        end
        // Door request wins over a simultaneous engine command.
        if (w_door_req && bus.engine != ENG_STOP) begin
          w_fault_nxt = 1'b1;
        end
      end
      ST_OPENING, ST_OPEN, ST_CLOSING: begin
        if (bus.engine != ENG_STOP) begin
          w_fault_nxt = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_floor     <= NUM_FLOORS'(1);
      r_dir_up    <= 1'b0;
      r_moving    <= 1'b0;
      r_arrive    <= 1'b0;
      r_door_open <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_floor     <= w_floor_nxt;
      r_dir_up    <= w_dir_up_nxt;
      r_moving    <= (w_state_nxt == ST_MOVING);
      r_arrive    <= (r_state == ST_MOVING) && w_done;
      r_door_open <= w_door_open_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

  assign bus.floor     = r_floor;
  assign bus.moving    = r_moving;
  assign bus.arrive    = r_arrive;
  assign bus.door_open = r_door_open;
  assign bus.fault     = r_fault;

endmodule

// File: tb/tb_car_plant.sv
// tb/tb_car_plant.sv - directed self-checking bench for car_plant
module tb_car_plant;
  import elevator_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  car_plant_if #(.NUM_FLOORS(3)) bus ();

  car_plant #(
    .NUM_FLOORS   (3),
    .TRAVEL_TICKS (8),
    .DOOR_TICKS   (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    bus.engine = ENG_STOP;
    bus.doors  = 3'b000;
    RST        = 1'b0;
    cyc(2);
    RST        = 1'b1;
    cyc(1);
  endtask

  initial begin
    bus.engine = ENG_STOP;
    bus.doors  = 3'b000;
    RST        = 1'b0;
    cyc(2);
    check_vec("rst_floor", bus.floor, 3'b001);
    check_vec("rst_moving", bus.moving, 0);
    check_vec("rst_arrive", bus.arrive, 0);
    check_vec("rst_door_open", bus.door_open, 3'b000);
    check_vec("rst_fault", bus.fault, 0);
    RST = 1'b1;
    cyc(1);

    // Hold up from floor 0: pass through floor 1, stop at floor 2.
    bus.engine = ENG_UP;
    for (int i = 0; i <= 16; i++) begin
      cyc(1);
      check_vec("t1_arrive", bus.arrive, (i == 8 || i == 16));
      check_vec("t1_floor", bus.floor, (i < 8) ? 3'b001 : (i < 16) ? 3'b010 : 3'b100);
      check_vec("t1_moving", bus.moving, (i < 16));
    end
    check_vec("t1_fault", bus.fault, 0);
    bus.engine = ENG_STOP;
    cyc(1);
    check_vec("t1_arrive_one_wide", bus.arrive, 0);

    // At floor 2, door request for floor 0 is illegal: fault, no motion.
    bus.doors = 3'b001;
    cyc(1);
    check_vec("t5_doors_fault", bus.fault, 1);
    cyc(5);
    check_vec("t5_no_door", bus.door_open, 3'b000);
    bus.doors = 3'b000;

    // Reserved engine code.
    do_reset();
    bus.engine = ENG_RSVD;
    cyc(1);
    bus.engine = ENG_STOP;
    check_vec("t5_rsvd_fault", bus.fault, 1);
    check_vec("t5_rsvd_moving", bus.moving, 0);

    // Two door bits at once, including the current floor.
    do_reset();
    bus.doors = 3'b011;
    cyc(1);
    check_vec("t5_multi_fault", bus.fault, 1);
    cyc(4);
    check_vec("t5_multi_no_door", bus.door_open, 3'b000);
    bus.doors = 3'b000;

    // Single-cycle up pulse: one segment, then stop at floor 1.
    do_reset();
    bus.engine = ENG_UP;
    cyc(1);
    bus.engine = ENG_STOP;
    check_vec("t2_moving_start", bus.moving, 1);
    for (int i = 1; i <= 9; i++) begin
      cyc(1);
      check_vec("t2_arrive", bus.arrive, (i == 8));
      check_vec("t2_floor", bus.floor, (i < 8) ? 3'b001 : 3'b010);
      check_vec("t2_moving", bus.moving, (i < 8));
    end

    // Door cycle at floor 1.
    bus.doors = 3'b010;
    for (int i = 0; i <= 4; i++) begin
      cyc(1);
      check_vec("t3_door_open", bus.door_open, (i >= 4) ? 3'b010 : 3'b000);
    end
    check_vec("t3_fault_clean", bus.fault, 0);
    bus.engine = ENG_DOWN;
    cyc(1);
    bus.engine = ENG_STOP;
    check_vec("t3_open_eng_fault", bus.fault, 1);
    check_vec("t3_floor_held", bus.floor, 3'b010);
    check_vec("t3_still_open", bus.door_open, 3'b010);
    check_vec("t3_not_moving", bus.moving, 0);
    // Drop doors while asking up: up is ignored until IDLE is reached.
    bus.doors  = 3'b000;
    bus.engine = ENG_UP;
    for (int i = 0; i <= 5; i++) begin
      cyc(1);
      check_vec("t3_closing_door", bus.door_open, 3'b000);
      check_vec("t3_close_moving", bus.moving, (i == 5));
    end
    bus.engine = ENG_STOP;

    // Down at floor 0 is illegal.
    do_reset();
    bus.engine = ENG_DOWN;
    cyc(1);
    bus.engine = ENG_STOP;
    check_vec("t4_fault", bus.fault, 1);
    check_vec("t4_moving", bus.moving, 0);
    check_vec("t4_floor", bus.floor, 3'b001);
    cyc(3);
    check_vec("t4_still_idle", bus.moving, 0);

    // Reset mid-segment from floor 1 upward.
    do_reset();
    bus.engine = ENG_UP;
    for (int i = 0; i <= 11; i++) begin
      cyc(1);
    end
    check_vec("t6_pre_floor", bus.floor, 3'b010);
    check_vec("t6_pre_moving", bus.moving, 1);
    RST = 1'b0;
    #1;
    check_vec("t6_rst_floor", bus.floor, 3'b001);
    check_vec("t6_rst_moving", bus.moving, 0);
    check_vec("t6_rst_arrive", bus.arrive, 0);
    check_vec("t6_rst_door", bus.door_open, 3'b000);
    check_vec("t6_rst_fault", bus.fault, 0);
    bus.engine = ENG_STOP;
    cyc(1);
    RST = 1'b1;
    cyc(1);
    bus.engine = ENG_UP;
    cyc(1);
    bus.engine = ENG_STOP;
    check_vec("t6_moving_start", bus.moving, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      check_vec("t6_arrive", bus.arrive, (i == 8));
      check_vec("t6_floor", bus.floor, (i < 8) ? 3'b001 : 3'b010);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
